upd7801_intc: RTL and testbench
===============================

# upd7801_intc

Interrupt controller and interval timer for the uPD7800-family CPU core. It synchronises and edge-detects the external interrupt pins and runs a 12-bit reload timer. It holds the pending and mask flags, arbitrates by fixed priority, and presents one request with its vector to the CPU. The CPU acknowledges service with a single-cycle handshake. The block sits between the SoC pins/timebase and the CPU's interrupt entry sequence.

## Interface
Parameters:
- TMR_W, 12: timer counter/reload width.
- VEC_BASE, 16'h0000: added to every vector offset.

Ports:
- CLK  in  1  system clock.
- RES  in  1  asynchronous, active-high reset.
- CE  in  1  state-advance enable; one pulse per CPU state (CP2 falling edge). All non-reset updates happen only when CE=1.
- INT0, INT1, INT2  in  1 each  asynchronous external interrupt pins.
- INT2_POL  in  1  INT2 active edge: 0 = falling, 1 = rising.
- IE  in  1  CPU interrupt-enable flag.
- MK_WE  in  1  mask write strobe, sampled with CE.
- MK_D  in  4  mask bits {INT2, INT1, INTT, INT0}; 1 = masked.
- TM_WE  in  1  timer reload write strobe, sampled with CE.
- TM_D  in  TMR_W  timer reload value.
- ACK  in  1  CPU accepts the presented request; one-CE pulse.
- IRQ  out  1  request to CPU.
- VEC  out  16  service vector, valid while IRQ=1.
- PEND  out  4  raw pending flags, same bit order as MK_D.
- MK  out  4  current mask.

## Operation
- Pins pass through a 2-FF synchroniser on CLK. Edge detection compares the synchronised value with the previous CE-sampled value.
  - INT0 and INT1 detect rising edges.
  - INT2 detects the edge selected by INT2_POL.
- A detected edge sets PEND[n] regardless of mask. The mask gates arbitration only.
- Timer:
  - TM_WE loads the reload register and the counter with TM_D, and starts the timer.
  - Each CE decrements the counter.
  - When the counter reaches 0, the next CE sets PEND[INTT] and reloads the counter.
  - Period is reload+1 CEs. Reload 0 sets PEND[INTT] every CE.
  - The timer is stopped after reset until the first TM_WE.
- Priority, highest first: INT0 > INTT > INT1 > INT2.
- Vector offsets: INT0 0x0004, INTT 0x0008, INT1 0x0010, INT2 0x0020. VEC = VEC_BASE + offset.
- `eligible` = PEND & ~MK, and IE=1.
- State machine (advances on CE):
  - IDLE: when any source is eligible, latch the winner as `sel`, drive VEC, and go to REQ.
  - REQ: IRQ=1; VEC and `sel` are frozen.
    - ACK: clear PEND[sel] and go to HOLD.
    - If IE=0, or `sel` becomes masked (without ACK), go back to IDLE. PEND is unchanged.
    - A higher-priority arrival during REQ does not preempt.
  - HOLD: IRQ=0 for one CE, then go to IDLE and re-arbitrate.
- Simultaneous events:
  - A new edge on `sel` in the same CE as its ACK clear: set wins, and PEND stays 1.
  - MK_WE and ACK in the same CE: both take effect.
  - TM_WE in the same CE as an underflow: TM_WE wins, and no INTT is set.
- ACK outside REQ is ignored.

## Timing
- Reset values:
  - IRQ=0, VEC=VEC_BASE+0x0004, PEND=0, MK=4'hF.
  - Timer stopped, counter 0, state IDLE.
  - Edge-detect history = current synchronised pin levels, so the first CE after reset sees no edge.
- Pin to PEND: 2 CLKs of synchronisation, then the next CE.
- PEND to IRQ: 1 CE (IDLE→REQ), provided IE=1 and the source is unmasked.
- ACK to IRQ low: the same CE edge, entering HOLD.
- Minimum spacing between back-to-back requests: 2 CEs after ACK.
- Counter is TMR_W bits and wraps only through reload; no carry-out is used.
- Reset mid-operation clears everything immediately, including REQ and HOLD.

## Structure
- Shared package `upd7801_pkg`:
  - typedef `e_intsrc` {INT0, INTT, INT1, INT2}.
  - Vector offset constants.
  - State enum `e_intc_st` {IDLE, REQ, HOLD}.
- Sub-module `upd7801_tmr`: reload counter plus underflow pulse, instantiated once.
- The synchronisers, edge detection, flags, arbiter and FSM stay in the top module.

## Test plan
- Reset, then IE=1, MK_D=4'h0 written, INT1 pulsed high → PEND=4'b0100. IRQ=1 with VEC=0x0010 one CE later; ACK → PEND=0 and IRQ=0 for one CE.
- INT2 and INT0 edges in the same CE, mask 0 → VEC=0x0004. After ACK and HOLD, VEC=0x0020.
- TM_WE with TM_D=3, INTT unmasked → PEND[INTT] on CEs 4, 8, 12. TM_WE with 3 again at CE 7 → next INTT at CE 11.
- MK=4'hF and INT1 edge → PEND=4'b0100 and IRQ=0. Write MK_D=0 → IRQ=1 on the next CE.
- In REQ for INT1, drop IE → IRQ=0 and PEND retained. Restore IE → REQ again with VEC=0x0010.
- INT1 edge in the same CE as ACK of INT1 → PEND[INT1] stays 1, and a second request follows after HOLD. Assert RES during REQ → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/upd7801_pkg.sv
// Shared types and constants for the uPD7801 interrupt controller.
// Source order matches the PEND/MK bit order, which is also the priority order.
package upd7801_pkg;

  typedef enum logic [1:0] {
    SRC_INT0 = 2'd0,
    SRC_INTT = 2'd1,
    SRC_INT1 = 2'd2,
    SRC_INT2 = 2'd3
  } e_intsrc;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } e_intc_st;

  localparam logic [15:0] VOFF_INT0 = 16'h0004;
  localparam logic [15:0] VOFF_INTT = 16'h0008;
  localparam logic [15:0] VOFF_INT1 = 16'h0010;
  localparam logic [15:0] VOFF_INT2 = 16'h0020;

  // Lowest set bit wins; only called when at least one bit is set.
  function automatic e_intsrc pick_src(input logic [3:0] elig);
    if (elig[0])      return SRC_INT0;
    else if (elig[1]) return SRC_INTT;
    else if (elig[2]) return SRC_INT1;
    else if (elig[3]) return SRC_INT2;
    else              return SRC_INT0;
  endfunction

  function automatic logic [15:0] vec_off(input e_intsrc s);
    case (s)
      SRC_INT0: return VOFF_INT0;
      SRC_INTT: return VOFF_INTT;
      SRC_INT1: return VOFF_INT1;
      default:  return VOFF_INT2;
    endcase
  endfunction

endpackage

// File: rtl/upd7801_tmr.sv
// Interval timer: reload counter that pulses uf_o on the CE after reaching zero.
// Stopped after reset until the first load.
module upd7801_tmr #(
  parameter int TMR_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             ld_i,
  input  logic [TMR_W-1:0] ld_val_i,
  output logic             uf_o
);

  logic             run_q, run_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] rld_q, rld_d;

  // A load in the same CE as an underflow suppresses the pulse.
  assign uf_o = ce_i & run_q & ~ld_i & (cnt_q == '0);

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    rld_d = rld_q;
    if (ce_i) begin
      if (ld_i) begin
        run_d = 1'b1;
        cnt_d = ld_val_i;
        rld_d = ld_val_i;
      end else if (run_q) begin
        cnt_d = (cnt_q == '0) ? rld_q : cnt_q - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rld_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rld_q <= rld_d;
    end
  end

endmodule

// File: rtl/upd7801_intc.sv
// uPD7801 interrupt controller: pin synchronisers, edge detect, pending/mask
// flags, fixed-priority arbiter and the IDLE/REQ/HOLD request handshake.
module upd7801_intc
  import upd7801_pkg::*;
#(
  parameter int          TMR_W    = 12,
  parameter logic [15:0] VEC_BASE = 16'h0000
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             CE,
  input  logic             INT0,
  input  logic             INT1,
  input  logic             INT2,
  input  logic             INT2_POL,
  input  logic             IE,
  input  logic             MK_WE,
  input  logic [3:0]       MK_D,
  input  logic             TM_WE,
  input  logic [TMR_W-1:0] TM_D,
  input  logic             ACK,
  output logic             IRQ,
  output logic [15:0]      VEC,
  output logic [3:0]       PEND,
  output logic [3:0]       MK
);

  // Pin vectors are {INT2, INT1, INT0}.
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  hist_q, hist_d;
  logic        armed_q, armed_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  mk_q, mk_d;
  e_intc_st    st_q, st_d;
  e_intsrc     sel_q, sel_d;
  logic [15:0] vec_q, vec_d;

  logic        tmr_uf;
  logic [2:0]  rise, fall;
  logic [3:0]  set_v, clr_v, elig;

  upd7801_tmr #(.TMR_W(TMR_W)) u_tmr (
    .clk_i    (CLK),
    .rst_i    (RES),
    .ce_i     (CE),
    .ld_i     (TM_WE),
    .ld_val_i (TM_D),
    .uf_o     (tmr_uf)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {INT2, INT1, INT0};
      sync2_q <= sync1_q;
    end
  end

  // History is not valid until the first CE after reset, so no edge is seen there.
  assign rise  = sync2_q & ~hist_q;
  assign fall  = ~sync2_q & hist_q;
  assign set_v = {(INT2_POL ? rise[2] : fall[2]) & armed_q,
                  rise[1] & armed_q,
                  tmr_uf,
                  rise[0] & armed_q};
  assign elig  = pend_q & ~mk_q & {4{IE}};

  always_comb begin
    st_d    = st_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    clr_v   = 4'b0000;
    pend_d  = pend_q;
    mk_d    = mk_q;
    hist_d  = hist_q;
    armed_d = armed_q;
    if (CE) begin
      case (st_q)
        ST_IDLE: begin
          if (|elig) begin
            sel_d = pick_src(elig);
            vec_d = VEC_BASE + vec_off(sel_d);
            st_d  = ST_REQ;
          end
        end
        ST_REQ: begin
          if (ACK) begin
            clr_v = 4'b0001 << sel_q;
            st_d  = ST_HOLD;
          end else if (!IE || mk_q[sel_q]) begin
            st_d = ST_IDLE;
          end
        end
        ST_HOLD: st_d = ST_IDLE;
        default: st_d = ST_IDLE;
      endcase
      // A new edge on the acknowledged source in the same CE keeps it pending.
      pend_d  = (pend_q & ~clr_v) | set_v;
      mk_d    = MK_WE ? MK_D : mk_q;
      hist_d  = sync2_q;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      st_q    <= ST_IDLE;
      sel_q   <= SRC_INT0;
      vec_q   <= VEC_BASE + VOFF_INT0;
      pend_q  <= 4'h0;
      mk_q    <= 4'hF;
      hist_q  <= 3'b000;
      armed_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
      mk_q    <= mk_d;
      hist_q  <= hist_d;
      armed_q <= armed_d;
    end
  end

  assign IRQ  = (st_q == ST_REQ);
  assign VEC  = vec_q;
  assign PEND = pend_q;
  assign MK   = mk_q;

endmodule

// File: tb/tb_upd7801_intc.sv
// Scoreboard bench for upd7801_intc: a per-CE reference model queues expected
// outputs, a monitor compares them after every CE edge.
module tb_upd7801_intc;

  localparam logic [15:0] VBASE = 16'h0000;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_HOLD = 2;

  logic        CLK = 1'b0;
  logic        RES, CE, INT0, INT1, INT2, INT2_POL, IE, MK_WE, TM_WE, ACK;
  logic [3:0]  MK_D;
  logic [11:0] TM_D;
  logic        IRQ;
  logic [15:0] VEC;
  logic [3:0]  PEND, MK;

  upd7801_intc #(.TMR_W(12), .VEC_BASE(VBASE)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .INT0(INT0), .INT1(INT1), .INT2(INT2),
    .INT2_POL(INT2_POL), .IE(IE), .MK_WE(MK_WE), .MK_D(MK_D), .TM_WE(TM_WE),
    .TM_D(TM_D), .ACK(ACK), .IRQ(IRQ), .VEC(VEC), .PEND(PEND), .MK(MK)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        irq;
    logic [15:0] vec;
    logic [3:0]  pend;
    logic [3:0]  mk;
  } out_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Stimulus variables for the next CE
  bit        pin0, pin1, pin2, pol, ie, mkwe, tmwe, ack;
  logic [3:0]  mkd;
  logic [11:0] tmd;

  // Reference model state
  bit          m_pend[4];
  bit          m_mask[4];
  bit          m_prev[3];
  int          m_mode, m_sel, m_phase, m_rld;
  bit          m_tmr_on;
  logic [15:0] m_vec;
  int          offs[4] = '{4, 8, 16, 32};

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_mask[i] = 1; end
    m_prev[0] = pin0; m_prev[1] = pin1; m_prev[2] = pin2;
    m_mode = M_IDLE; m_sel = 0; m_vec = VBASE + 16'h0004;
    m_tmr_on = 0; m_phase = 0; m_rld = 0;
  endtask

  task automatic model_step();
    bit elig[4];
    bit fire[4];
    bit found;
    int clr;
    found = 0;
    clr = -1;
    for (int i = 0; i < 4; i++) elig[i] = m_pend[i] && !m_mask[i] && ie;
    if (m_mode == M_IDLE) begin
      for (int i = 0; i < 4; i++)
        if (elig[i] && !found) begin found = 1; m_sel = i; end
      if (found) begin
        m_vec  = VBASE + 16'(offs[m_sel]);
        m_mode = M_REQ;
      end
    end else if (m_mode == M_REQ) begin
      if (ack) begin clr = m_sel; m_mode = M_HOLD; end
      else if (!ie || m_mask[m_sel]) m_mode = M_IDLE;
    end else begin
      m_mode = M_IDLE;
    end
    fire[0] = pin0 && !m_prev[0];
    fire[2] = pin1 && !m_prev[1];
    fire[3] = pol ? (pin2 && !m_prev[2]) : (!pin2 && m_prev[2]);
    fire[1] = 0;
    if (tmwe) begin
      m_tmr_on = 1; m_phase = 0; m_rld = int'(tmd);
    end else if (m_tmr_on) begin
      m_phase++;
      fire[1] = (m_phase % (m_rld + 1)) == 0;
    end
    if (clr >= 0) m_pend[clr] = 0;
    for (int i = 0; i < 4; i++) if (fire[i]) m_pend[i] = 1;
    if (mkwe) for (int i = 0; i < 4; i++) m_mask[i] = mkd[i];
    m_prev[0] = pin0; m_prev[1] = pin1; m_prev[2] = pin2;
  endtask

  function automatic out_t model_out();
    out_t o;
    o.irq  = (m_mode == M_REQ);
    o.vec  = m_vec;
    o.pend = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
    o.mk   = {m_mask[3], m_mask[2], m_mask[1], m_mask[0]};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // One CE: pins change right after the previous CE edge, strobes ride on CE.
  task automatic step();
    @(negedge CLK);
    CE = 0; MK_WE = 0; TM_WE = 0; ACK = 0;
    INT0 = pin0; INT1 = pin1; INT2 = pin2; INT2_POL = pol;
    @(negedge CLK);
    @(negedge CLK);
    CE = 1; IE = ie; MK_WE = mkwe; MK_D = mkd; TM_WE = tmwe; TM_D = tmd; ACK = ack;
    model_step();
    exp_q.push_back(model_out());
    @(posedge CLK);
    #2;
    CE = 0; MK_WE = 0; TM_WE = 0; ACK = 0;
    mkwe = 0; tmwe = 0; ack = 0;
  endtask

  out_t mon_e, mon_a;
  int   ce_n = 0;
  initial begin
    forever begin
      @(posedge CLK);
      if (CE === 1'b1 && RES === 1'b0) begin
        #1;
        ce_n++;
        mon_a = '{IRQ, VEC, PEND, MK};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ce%0d actual irq=%0b vec=%h pend=%b mk=%b required=none",
                   ce_n, mon_a.irq, mon_a.vec, mon_a.pend, mon_a.mk);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL out_ce%0d actual irq=%0b vec=%h pend=%b mk=%b required irq=%0b vec=%h pend=%b mk=%b",
                     ce_n, mon_a.irq, mon_a.vec, mon_a.pend, mon_a.mk,
                     mon_e.irq, mon_e.vec, mon_e.pend, mon_e.mk);
          end
        end
      end
    end
  end

  initial begin
    RES = 1; CE = 0; INT0 = 0; INT1 = 0; INT2 = 0; INT2_POL = 1; IE = 0;
    MK_WE = 0; MK_D = 0; TM_WE = 0; TM_D = 0; ACK = 0;
    pin0 = 0; pin1 = 0; pin2 = 0; pol = 1; ie = 0; mkwe = 0; tmwe = 0; ack = 0;
    mkd = 0; tmd = 0;
    repeat (3) @(negedge CLK);
    check("rst_irq",  32'(IRQ),  32'h0);
    check("rst_vec",  32'(VEC),  32'h4);
    check("rst_pend", 32'(PEND), 32'h0);
    check("rst_mk",   32'(MK),   32'hF);
    RES = 0;
    model_reset();

    // Single INT1 request and acknowledge
    ie = 1; mkwe = 1; mkd = 4'h0; step();
    pin1 = 1; step();
    check("int1_pend", 32'(PEND), 32'h4);
    check("int1_irq_early", 32'(IRQ), 32'h0);
    pin1 = 0; step();
    check("int1_irq", 32'(IRQ), 32'h1);
    check("int1_vec", 32'(VEC), 32'h10);
    ack = 1; step();
    check("int1_ack_pend", 32'(PEND), 32'h0);
    check("int1_ack_irq",  32'(IRQ),  32'h0);
    step();
    check("int1_idle_irq", 32'(IRQ), 32'h0);

    // INT0 and INT2 together: priority then second request after HOLD
    pin0 = 1; pin2 = 1; step();
    check("dual_pend", 32'(PEND), 32'h9);
    step();
    check("dual_vec0", 32'(VEC), 32'h4);
    check("dual_irq0", 32'(IRQ), 32'h1);
    ack = 1; step();
    step();
    step();
    check("dual_vec2", 32'(VEC), 32'h20);
    check("dual_irq2", 32'(IRQ), 32'h1);
    ack = 1; pin0 = 0; pin2 = 0; step();
    step();

    // Timer period and reload restart
    tmwe = 1; tmd = 12'd3; step();
    for (int c = 1; c <= 14; c++) begin
      if (m_mode == M_REQ) ack = 1;
      if (c == 7) begin tmwe = 1; tmd = 12'd3; end
      step();
      if (c == 4 || c == 11) check($sformatf("tmr_set_ce%0d", c), 32'(PEND[1]), 32'h1);
      if (c == 3 || c == 8 || c == 10) check($sformatf("tmr_clr_ce%0d", c), 32'(PEND[1]), 32'h0);
    end
    tmwe = 1; tmd = 12'hFFF; step();

    // Masked pending, then unmask
    mkwe = 1; mkd = 4'hF; step();
    pin1 = 1; step();
    check("mask_pend", 32'(PEND), 32'h4);
    check("mask_irq",  32'(IRQ),  32'h0);
    pin1 = 0; mkwe = 1; mkd = 4'h0; step();
    check("unmask_irq_same", 32'(IRQ), 32'h0);
    step();
    check("unmask_irq", 32'(IRQ), 32'h1);
    check("unmask_vec", 32'(VEC), 32'h10);

    // IE drop during REQ
    ie = 0; step();
    check("iedrop_irq",  32'(IRQ),  32'h0);
    check("iedrop_pend", 32'(PEND), 32'h4);
    ie = 1; step();
    check("ierest_irq", 32'(IRQ), 32'h1);
    check("ierest_vec", 32'(VEC), 32'h10);

    // New edge coinciding with its own ACK
    ack = 1; pin1 = 1; step();
    check("setwins_pend", 32'(PEND), 32'h4);
    check("setwins_irq",  32'(IRQ),  32'h0);
    pin1 = 0; step();
    step();
    check("rereq_irq", 32'(IRQ), 32'h1);
    check("rereq_vec", 32'(VEC), 32'h10);

    // Asynchronous reset in REQ
    #1;
    RES = 1;
    #1;
    check("arst_irq",  32'(IRQ),  32'h0);
    check("arst_vec",  32'(VEC),  32'h4);
    check("arst_pend", 32'(PEND), 32'h0);
    check("arst_mk",   32'(MK),   32'hF);
    repeat (2) @(negedge CLK);
    RES = 0;
    model_reset();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) pin0 = !pin0;
      if ($urandom_range(3) == 0) pin1 = !pin1;
      if ($urandom_range(3) == 0) pin2 = !pin2;
      if ($urandom_range(15) == 0) pol = !pol;
      ie   = ($urandom_range(7) != 0);
      mkwe = ($urandom_range(5) == 0);
      mkd  = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom_range(15));
      tmwe = ($urandom_range(29) == 0);
      tmd  = 12'($urandom_range(6));
      ack  = (m_mode == M_REQ) ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
      step();
    end

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
